uart_tx: RTL and testbench
==========================

# uart_tx

Byte-wide UART transmitter. It is the transmit-side counterpart of the team's UART receiver, sharing its run-time `cycles_per_databit` bit-period control, 8N1 framing and level-held request handshake. It sits between the FPGA-side data source and the Bluetooth module's RX pin. It accepts one byte per request, serialises it as start bit, eight data bits LSB-first, and one stop bit, then holds a done flag until the requester releases the request.

## Interface
Parameters:
- none; the bit period is a run-time input.

Ports (clock and reset first):
- `clk`  input  1  system clock.
- `resetn`  input  1  reset; one clock, synchronous, active-low.
- `cycles_per_databit`  input  10  clock cycles per serial bit. Values 0 and 1 are treated as 2.
- `tx_start`  input  1  level-held transmit request.
- `tx_data`  input  8  byte to send. Sampled only on the accept cycle.
- `tx_line`  output  1  serial line. Idle-high, registered.
- `tx_busy`  output  1  high from the accept cycle through the end of the stop bit.
- `tx_done`  output  1  high in the Done state.

## Operation
- States are Idle, Start_Bit, Data_Bits, Stop_Bit and Done. A 3-bit state register is updated on `posedge clk`.
- **Idle**
  - `tx_line`=1.
  - If `tx_start`=1, accept the request:
    - latch `tx_data` into the shift register;
    - latch the clamped `cycles_per_databit` into the period register;
    - clear the bit timer and the bit index;
    - go to Start_Bit.
- **Start_Bit**
  - `tx_line`=0 for one period, then go to Data_Bits.
- **Data_Bits**
  - `tx_line` = shift register bit 0.
  - At the end of each period, shift right by 1 and increment the 4-bit index.
  - After index 7 completes, go to Stop_Bit.
- **Stop_Bit**
  - `tx_line`=1 for one period, then go to Done.
- **Done**
  - `tx_line`=1, `tx_done`=1.
  - Stay while `tx_start`=1. When `tx_start`=0, go to Idle on the next edge.
- **Bit timer**
  - 10-bit counter that counts 0 up to period−1.
  - It wraps to 0 at the terminal count; the period ends at terminal count.
  - Compare against the latched period only; changes on `cycles_per_databit` mid-frame have no effect.
- `tx_data` and `tx_start` are ignored outside Idle; only Done's exit condition reads `tx_start`.
- `tx_busy` = state is Start_Bit, Data_Bits or Stop_Bit, or the accept cycle.

## Timing
- **Reset** (`resetn`=0 at a rising edge):
  - state Idle, `tx_line`=1, `tx_busy`=0, `tx_done`=0;
  - timer, index and shift register all 0.
  - Reset mid-frame aborts the frame, and the line returns high at that edge.
- **Accept:** `tx_start`=1 sampled in Idle at edge N. `tx_line` falls at edge N+1 (one cycle latency).
- **Bit lengths:** each bit occupies exactly P = max(2, `cycles_per_databit`) cycles. The full frame is 10·P cycles from the start-bit falling edge to the end of the stop bit.
- **Done:** `tx_done` rises at the edge ending the stop bit.
  - If `tx_start` is already 0, Done lasts exactly one cycle.
  - The earliest next accept is the cycle after Done, so at least 1 idle-high cycle separates frames.
- **Level request:** a `tx_start` held continuously high produces exactly one frame. A second frame needs a 0 then a 1.
- **Index width:** the index never exceeds 8; no wrap is possible.

## Test plan
- **Reset idle:** `resetn`=0 for 2 cycles, then 1, with `tx_start`=0 → `tx_line`=1, `tx_busy`=0, `tx_done`=0 for 50 cycles.
- **Basic frame:** `cycles_per_databit`=10, `tx_data`=8'hA5, `tx_start` pulsed with release during the frame → `tx_line` sequence per 10-cycle bit is 0,1,0,1,0,0,1,0,1,1. Start falls 1 cycle after accept. `tx_done` is high for exactly 1 cycle at cycle 100 after the falling edge.
- **Held request:** `tx_start` held high through 3 frame lengths, `tx_data`=8'h3C → exactly one frame and `tx_done` stays high. Drop `tx_start` → Idle next cycle. Raise it again → a second frame starts 1 cycle later.
- **Mid-frame changes:** change `cycles_per_databit` from 10 to 4 and `tx_data` to 8'hFF during bit 3 → the remaining bits stay 10 cycles and the transmitted byte is unchanged. The next frame uses 4-cycle bits.
- **Clamp:** `cycles_per_databit`=0, `tx_data`=8'h01 → 2-cycle bits, 20-cycle frame, sequence 0,1,0,0,0,0,0,0,0,1.
- **Abort:** assert `resetn`=0 during bit 5 → `tx_line`=1 and `tx_busy`=0 at that edge. A new request after release sends a complete, correct frame.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - Byte-wide 8N1 UART transmitter with run-time bit period
//
// Ports:
//   clk                 system clock
//   resetn              synchronous active-low reset
//   cycles_per_databit  clock cycles per serial bit (0 and 1 behave as 2)
//   tx_start            level-held transmit request
//   tx_data             byte to send, sampled on the accept cycle only
//   tx_line             serial output, idle-high, registered
//   tx_busy             high from the accept cycle through the stop bit
//   tx_done             high once the frame is finished, until tx_start drops

module uart_tx (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] cycles_per_databit,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state, state_d;
    logic [9:0] timer_q, timer_d;
    logic [9:0] period_q, period_d;
    logic [3:0] index_q, index_d;
    logic [7:0] shift_q, shift_d;
    logic       line_d;
    logic       done_d;
    logic       bit_end;
    logic [9:0] timer_next;

    // The period register is only ever loaded with a clamped value (>= 2),
    // so period_q - 1 cannot underflow while a frame is in flight.
    assign bit_end    = (timer_q == (period_q - 10'd1));
    assign timer_next = bit_end ? 10'd0 : (timer_q + 10'd1);

    // The accept cycle counts as busy; resetn gates it so a held request
    // does not show busy while the block is being reset.
    assign tx_busy = (state == S_START) || (state == S_DATA) || (state == S_STOP) ||
                     ((state == S_IDLE) && tx_start && resetn);

    always_comb begin
        state_d  = state;
        timer_d  = timer_q;
        period_d = period_q;
        index_d  = index_q;
        shift_d  = shift_q;
        line_d   = 1'b1;
        done_d   = (state == S_DONE);

        case (state)
            S_IDLE: begin
                line_d  = 1'b1;
                timer_d = 10'd0;
                if (tx_start) begin
                    shift_d  = tx_data;
                    period_d = (cycles_per_databit < 10'd2) ? 10'd2 : cycles_per_databit;
                    timer_d  = 10'd0;
                    index_d  = 4'd0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                line_d  = 1'b0;
                timer_d = timer_next;
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                line_d  = shift_q[0];
                timer_d = timer_next;
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    index_d = index_q + 4'd1;
                    if (index_q == 4'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                line_d  = 1'b1;
                timer_d = timer_next;
                if (bit_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                line_d  = 1'b1;
                timer_d = 10'd0;
                if (!tx_start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 10'd0;
                index_d = 4'd0;
            end
        endcase
    end

    // Line and done are registered from the current state, so the line
    // lags the state by one clock: accept at edge N, start bit at edge N+1.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            timer_q  <= 10'd0;
            period_q <= 10'd2;
            index_q  <= 4'd0;
            shift_q  <= 8'd0;
            tx_line  <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_d;
            timer_q  <= timer_d;
            period_q <= period_d;
            index_q  <= index_d;
            shift_q  <= shift_d;
            tx_line  <= line_d;
            tx_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - Self-checking bench for uart_tx

module tb_uart_tx;

    logic       clk;
    logic       resetn;
    logic [9:0] cycles_per_databit;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_line;
    logic       tx_busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    uart_tx dut (
        .clk                (clk),
        .resetn             (resetn),
        .cycles_per_databit (cycles_per_databit),
        .tx_start           (tx_start),
        .tx_data            (tx_data),
        .tx_line            (tx_line),
        .tx_busy            (tx_busy),
        .tx_done            (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] cpd;
        string      name;
    } vec_t;

    vec_t vecs[8];

    // Reference: frame bit i (0 start, 1..8 data LSB first, 9 stop) spans
    // samples k = 1 + i*p .. (i+1)*p after the accept edge; idle-high elsewhere.
    function automatic logic exp_line(input logic [7:0] d, input int p, input int k);
        int i;
        if (k < 1 || k > 10 * p) return 1'b1;
        i = (k - 1) / p;
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return (d >> (i - 1)) & 8'd1;
    endfunction

    function automatic int clamp_p(input logic [9:0] cpd);
        return (cpd < 10'd2) ? 2 : int'(cpd);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Pulsed request; optional mid-frame change of period/data at sample chg_k.
    task automatic run_frame(input logic [7:0] d, input logic [9:0] cpd, input int chg_k,
                             input logic [9:0] chg_cpd, input logic [7:0] chg_d,
                             input string name);
        int p;
        int bl, bb, bd;
        logic el, eb, ed;
        p  = clamp_p(cpd);
        bl = 0; bb = 0; bd = 0;
        tx_data            = d;
        cycles_per_databit = cpd;
        tx_start           = 1'b1;
        #1;
        check1({name, " accept_busy"}, tx_busy, 1'b1);
        for (int k = 0; k <= 10 * p + 2; k++) begin
            step();
            if (k == 0) tx_start = 1'b0;
            el = exp_line(d, p, k);
            eb = (k < 10 * p);
            ed = (k == 10 * p + 1);
            if (tx_line !== el && bl == 0) begin
                bl = 1;
                $display("FAIL %s line at cycle %0d: got %b expected %b", name, k, tx_line, el);
            end
            if (tx_busy !== eb && bb == 0) begin
                bb = 1;
                $display("FAIL %s busy at cycle %0d: got %b expected %b", name, k, tx_busy, eb);
            end
            if (tx_done !== ed && bd == 0) begin
                bd = 1;
                $display("FAIL %s done at cycle %0d: got %b expected %b", name, k, tx_done, ed);
            end
            if (k == chg_k) begin
                cycles_per_databit = chg_cpd;
                tx_data            = chg_d;
            end
        end
        checks += 3;
        errors += bl + bb + bd;
    endtask

    initial begin
        int bl, bb, bd;
        logic el;

        vecs[0] = '{8'hA5, 10'd10, "basic_a5"};
        vecs[1] = '{8'h01, 10'd0,  "clamp0_01"};
        vecs[2] = '{8'h80, 10'd1,  "clamp1_80"};
        vecs[3] = '{8'hFF, 10'd2,  "p2_ff"};
        vecs[4] = '{8'h00, 10'd3,  "p3_00"};
        vecs[5] = '{8'h3C, 10'd5,  "p5_3c"};
        vecs[6] = '{8'h55, 10'd7,  "p7_55"};
        vecs[7] = '{8'h96, 10'd13, "p13_96"};

        resetn             = 1'b0;
        tx_start           = 1'b0;
        tx_data            = 8'h00;
        cycles_per_databit = 10'd10;

        step();
        step();
        check1("reset_line", tx_line, 1'b1);
        check1("reset_busy", tx_busy, 1'b0);
        check1("reset_done", tx_done, 1'b0);
        resetn = 1'b1;

        bl = 0; bb = 0; bd = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (tx_line !== 1'b1) bl = 1;
            if (tx_busy !== 1'b0) bb = 1;
            if (tx_done !== 1'b0) bd = 1;
        end
        check1("idle_line", bl == 0, 1'b1);
        check1("idle_busy", bb == 0, 1'b1);
        check1("idle_done", bd == 0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].data, vecs[i].cpd, -1, 10'd0, 8'd0, vecs[i].name);
        end

        // Held request: one frame only, done stays up while tx_start is held.
        tx_data            = 8'h3C;
        cycles_per_databit = 10'd10;
        tx_start           = 1'b1;
        bl = 0; bb = 0; bd = 0;
        for (int k = 0; k <= 300; k++) begin
            step();
            el = exp_line(8'h3C, 10, k);
            if (tx_line !== el && bl == 0) begin
                bl = 1;
                $display("FAIL held line at cycle %0d: got %b expected %b", k, tx_line, el);
            end
            if (tx_busy !== (k < 100) && bb == 0) begin
                bb = 1;
                $display("FAIL held busy at cycle %0d: got %b expected %b", k, tx_busy, k < 100);
            end
            if (tx_done !== (k >= 101) && bd == 0) begin
                bd = 1;
                $display("FAIL held done at cycle %0d: got %b expected %b", k, tx_done, k >= 101);
            end
        end
        checks += 3;
        errors += bl + bb + bd;
        tx_start = 1'b0;
        step();
        check1("held_release_busy", tx_busy, 1'b0);
        check1("held_release_line", tx_line, 1'b1);
        run_frame(8'h3C, 10'd10, -1, 10'd0, 8'd0, "held_second");

        // Mid-frame period/data change during data bit 3 is ignored.
        run_frame(8'h5A, 10'd10, 45, 10'd4, 8'hFF, "midchg_5a");
        run_frame(8'hFF, 10'd4, -1, 10'd0, 8'd0, "midchg_next_p4");

        // Abort by reset during data bit 5, then a clean frame.
        tx_data            = 8'h96;
        cycles_per_databit = 10'd6;
        tx_start           = 1'b1;
        bl = 0;
        for (int k = 0; k <= 39; k++) begin
            step();
            if (k == 0) tx_start = 1'b0;
            el = exp_line(8'h96, 6, k);
            if (tx_line !== el && bl == 0) begin
                bl = 1;
                $display("FAIL abort_prefix line at cycle %0d: got %b expected %b", k, tx_line, el);
            end
        end
        checks++;
        errors += bl;
        resetn = 1'b0;
        step();
        check1("abort_line", tx_line, 1'b1);
        check1("abort_busy", tx_busy, 1'b0);
        check1("abort_done", tx_done, 1'b0);
        resetn = 1'b1;
        step();
        run_frame(8'hC3, 10'd6, -1, 10'd0, 8'd0, "after_abort");

        // Randomized frames against the reference.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] rd;
            logic [9:0] rc;
            int gap;
            rd  = 8'($urandom);
            rc  = 10'($urandom_range(0, 12));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step();
            run_frame(rd, rc, -1, 10'd0, 8'd0, $sformatf("rand%0d_%02h_p%0d", i, rd, rc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
